// File: rtl/gradient_accumulator.sv
// rtl/gradient_accumulator.sv - sums NUM_WORKERS gradient batches lane-wise and streams the round total
module gradient_accumulator #(
    parameter int NUM_WORKERS = 4,
    parameter int MAX_LINES   = 64,
    parameter int LANE_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [511:0] in_data,
    input  logic         in_batch_end,
    input  logic [31:0]  in_n,
    output logic         in_ready,
    output logic         out_valid,
    output logic [511:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         round_done,
    output logic         err
);

    localparam int DW    = 512;
    localparam int LANES = DW / LANE_W;
    localparam int AW    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int IW    = 16;
    localparam int WW    = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    typedef enum logic {S_ACCUM, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   worker_cnt_q, worker_cnt_d;
    logic [IW-1:0]   line_idx_q, line_idx_d;
    logic [IW-1:0]   num_lines_q, num_lines_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [31:0]     ref_n_q, ref_n_d;
    logic            err_q, err_d;
    logic            round_done_q, round_done_d;
    logic            skid_valid_q, skid_valid_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic            skid_end_q, skid_end_d;
    logic [31:0]     skid_n_q, skid_n_d;

    logic [DW-1:0]   acc_q [MAX_LINES];
    logic            acc_we;
    logic [DW-1:0]   acc_wdata;
    logic [DW-1:0]   acc_rd;
    logic [DW-1:0]   lane_sum;

    logic            beat_valid;
    logic [DW-1:0]   beat_data;
    logic            beat_end;
    logic [31:0]     beat_n;
    logic            worker_last;
    logic            drain_last;

    // A parked skid beat always goes before whatever arrives in the same cycle.
    always_comb begin
        beat_valid = (state_q == S_ACCUM) && (skid_valid_q || in_valid);
        beat_data  = skid_valid_q ? skid_data_q : in_data;
        beat_end   = skid_valid_q ? skid_end_q  : in_batch_end;
        beat_n     = skid_valid_q ? skid_n_q    : in_n;
    end

    assign worker_last = (worker_cnt_q == WW'(NUM_WORKERS - 1));
    assign drain_last  = (rd_idx_q == num_lines_q - 1'b1);
    assign acc_rd      = acc_q[line_idx_q[AW-1:0]];

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i*LANE_W +: LANE_W] = acc_rd[i*LANE_W +: LANE_W] + beat_data[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ACCUM;
            worker_cnt_q <= '0;
            line_idx_q   <= '0;
            num_lines_q  <= '0;
            rd_idx_q     <= '0;
            ref_n_q      <= '0;
            err_q        <= 1'b0;
            round_done_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_end_q   <= 1'b0;
            skid_n_q     <= '0;
        end else begin
            state_q      <= state_d;
            worker_cnt_q <= worker_cnt_d;
            line_idx_q   <= line_idx_d;
            num_lines_q  <= num_lines_d;
            rd_idx_q     <= rd_idx_d;
            ref_n_q      <= ref_n_d;
            err_q        <= err_d;
            round_done_q <= round_done_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_end_q   <= skid_end_d;
            skid_n_q     <= skid_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc_we) begin
            acc_q[line_idx_q[AW-1:0]] <= acc_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCUM: if (beat_valid && beat_end && worker_last) state_d = S_DRAIN;
            S_DRAIN: if (out_ready && drain_last) state_d = S_ACCUM;
            default: state_d = S_ACCUM;
        endcase
    end

    always_comb begin
        worker_cnt_d = worker_cnt_q;
        line_idx_d   = line_idx_q;
        num_lines_d  = num_lines_q;
        rd_idx_d     = rd_idx_q;
        ref_n_d      = ref_n_q;
        err_d        = err_q;
        round_done_d = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_end_d   = skid_end_q;
        skid_n_d     = skid_n_q;
        acc_we       = 1'b0;
        acc_wdata    = lane_sum;

        if (in_valid && (skid_valid_q || state_q == S_DRAIN)) begin
            if (state_q == S_DRAIN && skid_valid_q) begin
                err_d = 1'b1;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_end_d   = in_batch_end;
                skid_n_d     = in_n;
            end
        end else if (state_q == S_ACCUM && skid_valid_q) begin
            skid_valid_d = 1'b0;
        end

        if (beat_valid) begin
            if (line_idx_q < IW'(MAX_LINES)) begin
                acc_we    = 1'b1;
                acc_wdata = (worker_cnt_q == '0) ? beat_data : lane_sum;
            end else begin
                err_d = 1'b1;
            end
            if (line_idx_q == '0) begin
                if (worker_cnt_q == '0) ref_n_d = beat_n;
                else if (beat_n != ref_n_q) err_d = 1'b1;
            end
            if (beat_end) begin
                line_idx_d = '0;
                if (worker_cnt_q == '0) num_lines_d = line_idx_q + 1'b1;
                else if (line_idx_q + 1'b1 != num_lines_q) err_d = 1'b1;
                if (worker_last) rd_idx_d = '0;
                else worker_cnt_d = worker_cnt_q + 1'b1;
            end else begin
                line_idx_d = line_idx_q + 1'b1;
            end
        end

        if (state_q == S_DRAIN && out_ready) begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (drain_last) begin
                worker_cnt_d = '0;
                line_idx_d   = '0;
                round_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == S_ACCUM);
        out_valid  = (state_q == S_DRAIN);
        out_last   = (state_q == S_DRAIN) && drain_last;
        out_data   = (state_q == S_DRAIN) ? acc_q[rd_idx_q[AW-1:0]] : '0;
        round_done = round_done_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_gradient_accumulator.sv
// tb/tb_gradient_accumulator.sv - directed self-checking bench for gradient_accumulator
module tb_gradient_accumulator;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_batch_end;
    logic [31:0]  in_n;
    logic         in_ready;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         round_done;
    logic         err;

    int total = 0;
    int bad   = 0;

    gradient_accumulator #(.NUM_WORKERS(4), .MAX_LINES(64), .LANE_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_batch_end(in_batch_end), .in_n(in_n),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .round_done(round_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rep(input logic [31:0] v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    task automatic drive(input logic [511:0] d, input logic e, input logic [31:0] n);
        in_valid     = 1'b1;
        in_data      = d;
        in_batch_end = e;
        in_n         = n;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_batch_end = 1'b0;
        in_data      = '0;
    endtask

    logic [511:0] w;
    logic [511:0] exp_a;
    logic [511:0] exp_b [3];
    logic         pat [6];
    int           k;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_batch_end = 1'b0; in_n = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_err", err, 0);

        // 1-line batches; lane 0 checks 32-bit wrap without disturbing lane 1
        w = rep(1); w[31:0] = 32'hFFFF_FFFF; drive(w, 1'b1, 15);
        w = rep(2); w[31:0] = 32'h0000_0001; drive(w, 1'b1, 15);
        w = rep(3); w[31:0] = 32'h0;         drive(w, 1'b1, 15);
        w = rep(4); w[31:0] = 32'h0;         drive(w, 1'b1, 15);
        exp_a = rep(10); exp_a[31:0] = 32'h0;
        chk("a_out_valid", out_valid, 1);
        chk("a_in_ready", in_ready, 0);
        chk("a_out_last", out_last, 1);
        chk("a_out_data", out_data, exp_a);
        chk("a_err", err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("a_round_done", round_done, 1);
        chk("a_out_valid_off", out_valid, 0);
        chk("a_out_data_zero", out_data, 0);
        chk("a_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        chk("a_round_done_pulse", round_done, 0);

        // 3-line batches, lane value = worker + line
        for (int wk = 0; wk < 4; wk++)
            for (int ln = 0; ln < 3; ln++)
                drive(rep(32'(wk + ln)), ln == 2, 47);
        // beat one cycle after the final batch end lands in the skid
        drive(rep(5), 1'b1, 15);
        exp_b[0] = rep(6); exp_b[1] = rep(10); exp_b[2] = rep(14);
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("b_valid_c%0d", c), out_valid, 1);
            chk($sformatf("b_data_c%0d", c), out_data, exp_b[k]);
            chk($sformatf("b_last_c%0d", c), out_last, k == 2);
            out_ready = pat[c];
            @(posedge clk); #1;
            if (pat[c]) k++;
        end
        out_ready = 1'b0;
        chk("b_round_done", round_done, 1);
        chk("b_in_ready", in_ready, 1);

        drive(rep(6), 1'b1, 15);
        drive(rep(7), 1'b1, 15);
        drive(rep(8), 1'b1, 15);
        for (int t = 0; t < 10 && !out_valid; t++) begin
            @(posedge clk); #1;
        end
        chk("s_out_valid", out_valid, 1);
        chk("s_out_data", out_data, rep(26));
        chk("s_out_last", out_last, 1);
        chk("s_err", err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("s_round_done", round_done, 1);

        // element count mismatch on worker 1, then reset mid-drain
        drive(rep(1), 1'b1, 15);
        chk("e_err_before", err, 0);
        drive(rep(1), 1'b1, 31);
        chk("e_err_set", err, 1);
        drive(rep(1), 1'b1, 15);
        drive(rep(1), 1'b1, 15);
        chk("e_err_sticky", err, 1);
        chk("e_drain", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("r_out_valid", out_valid, 0);
        chk("r_in_ready", in_ready, 1);
        chk("r_err", err, 0);
        chk("r_out_data", out_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
